// File: rtl/rounder_pkg.sv
// Shared types and constants for the FPU rounder sequencer.
package rounder_pkg;

    localparam int FR_W    = 57;
    localparam int ER_W    = 13;
    localparam int SIG_W   = 53;
    localparam int SIG_W_S = 24;
    localparam int LZ_W    = 6;

    // Kept-field LSB and guard-bit positions within the normalized significand.
    localparam int KEEP_LSB_D = 4;
    localparam int KEEP_LSB_S = 33;
    localparam int GUARD_D    = 3;
    localparam int GUARD_S    = 32;

    localparam logic [ER_W-1:0] EMAX_D = 13'h07FF;
    localparam logic [ER_W-1:0] EMAX_S = 13'h00FF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FLAG,
        ST_NORM,
        ST_RND,
        ST_OUT
    } state_e;

    typedef enum logic [1:0] {
        RM_RNE = 2'b00,
        RM_RZ  = 2'b01,
        RM_RU  = 2'b10,
        RM_RD  = 2'b11
    } rm_e;

endpackage

// File: rtl/rnd_decide.sv
// Rounding increment and inexact decision from guard, sticky, kept LSB, sign
// and rounding mode.
module rnd_decide
    import rounder_pkg::*;
(
    input  logic g_i,
    input  logic s_i,
    input  logic lsb_i,
    input  logic sign_i,
    input  rm_e  rm_i,
    output logic inc_o,
    output logic inx_o
);

    // Select the increment rule for the active rounding mode.
    always_comb begin
        inc_o = 1'b0;
        inx_o = g_i | s_i;
        unique case (rm_i)
            RM_RNE:  inc_o = g_i & (s_i | lsb_i);
            RM_RZ:   inc_o = 1'b0;
            RM_RU:   inc_o = ~sign_i & (g_i | s_i);
            RM_RD:   inc_o = sign_i & (g_i | s_i);
            default: inc_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/rnd_flags.sv
// Pre-rounding flag evaluation: leading-zero count of the significand and
// tiny/overflow detection on the normalized exponent (er - lz, computed one
// bit wider so it cannot wrap). A zero significand raises no flags.
module rnd_flags
    import rounder_pkg::*;
(
    input  logic [FR_W-1:0] fr_i,
    input  logic [ER_W-1:0] er_i,
    input  logic            db_i,
    output logic            tiny_o,
    output logic            ovf1_o,
    output logic [LZ_W-1:0] lz_o
);

    logic signed [ER_W:0] e_ext;
    logic signed [ER_W:0] emax_ext;
    logic                 nz;

    // Priority encode the most significant set bit into a left-shift count.
    always_comb begin
        lz_o = LZ_W'(FR_W);
        for (int unsigned i = 0; i < FR_W; i++) begin
            if (fr_i[i]) lz_o = LZ_W'(FR_W - 1 - i);
        end
    end

    // Classify the normalized exponent against the precision's range.
    always_comb begin
        nz       = |fr_i;
        e_ext    = $signed({er_i[ER_W-1], er_i}) - $signed({{(ER_W + 1 - LZ_W){1'b0}}, lz_o});
        emax_ext = $signed({1'b0, (db_i ? EMAX_D : EMAX_S)});
        tiny_o   = nz & (e_ext < $signed(14'sd1));
        ovf1_o   = nz & (e_ext >= emax_ext);
    end

endmodule

// File: rtl/rounder_ctrl.sv
// Multi-cycle rounder sequencer: IDLE -> FLAG -> NORM -> RND -> OUT.
// One result in flight; outputs registered on entry to OUT.
// Optional accumulated exception flags: define RND_STICKY_FLAGS_EN.
module rounder_ctrl
    import rounder_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [FR_W-1:0]  in_fr,
    input  logic [ER_W-1:0]  in_er,
    input  logic             in_db,
    input  logic             in_sign,
    input  logic [1:0]       in_rm,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [SIG_W-1:0] out_sig,
    output logic [ER_W-1:0]  out_exp,
    output logic             out_sign,
    output logic             out_tiny,
    output logic             out_ovf,
    output logic             out_inx,
    input  logic             flags_clr,
    output logic [2:0]       sticky_flags
);

    state_e            state_q, state_d;
    logic [FR_W-1:0]   fr_q, fn_q;
    logic [ER_W-1:0]   er_q, en_q;
    logic              db_q, sign_q;
    rm_e               rm_q;
    logic              tiny_q, ovf1_q;
    logic [LZ_W-1:0]   lz_q;

    logic [SIG_W-1:0]  sig_q;
    logic [ER_W-1:0]   exp_q;
    logic              osign_q, otiny_q, oovf_q, oinx_q;

    logic              fl_tiny, fl_ovf1;
    logic [LZ_W-1:0]   fl_lz;

    logic [SIG_W-1:0]  kept;
    logic [SIG_W:0]    sum;
    logic              g, s, inc, inx, carry;
    logic [SIG_W-1:0]  sig_d;
    logic [ER_W-1:0]   exp_d;
    logic              tiny_d, ovf_d, inx_d;

    rnd_flags u_flags (
        .fr_i   (fr_q),
        .er_i   (er_q),
        .db_i   (db_q),
        .tiny_o (fl_tiny),
        .ovf1_o (fl_ovf1),
        .lz_o   (fl_lz)
    );

    rnd_decide u_decide (
        .g_i    (g),
        .s_i    (s),
        .lsb_i  (kept[0]),
        .sign_i (sign_q),
        .rm_i   (rm_q),
        .inc_o  (inc),
        .inx_o  (inx)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // Next-state sequencing through the shared datapath steps.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (in_valid) state_d = ST_FLAG;
            ST_FLAG: state_d = ST_NORM;
            ST_NORM: state_d = ST_RND;
            ST_RND:  state_d = ST_OUT;
            ST_OUT:  if (out_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Rounding of the normalized significand, with carry-out renormalization.
    always_comb begin
        kept   = db_q ? fn_q[FR_W-1:KEEP_LSB_D]
                      : {{(SIG_W - SIG_W_S){1'b0}}, fn_q[FR_W-1:KEEP_LSB_S]};
        g      = db_q ? fn_q[GUARD_D] : fn_q[GUARD_S];
        s      = db_q ? |fn_q[GUARD_D-1:0] : |fn_q[GUARD_S-1:0];
        sum    = {1'b0, kept} + {{SIG_W{1'b0}}, inc};
        carry  = db_q ? sum[SIG_W] : sum[SIG_W_S];
        sig_d  = sum[SIG_W-1:0];
        exp_d  = en_q;
        if (carry) begin
            sig_d = db_q ? (SIG_W'(1) << (SIG_W - 1)) : (SIG_W'(1) << (SIG_W_S - 1));
            exp_d = en_q + ER_W'(1);
        end
        tiny_d = tiny_q;
        ovf_d  = ovf1_q | (carry & (exp_d == (db_q ? EMAX_D : EMAX_S)));
        inx_d  = inx;
        if (~|fn_q) begin
            sig_d  = '0;
            exp_d  = '0;
            tiny_d = 1'b0;
            ovf_d  = 1'b0;
            inx_d  = 1'b0;
        end
    end

    // Datapath registers, each loaded in the state that owns it.
    always_ff @(posedge clk) begin
        if (rst) begin
            sig_q   <= '0;
            exp_q   <= '0;
            osign_q <= 1'b0;
            otiny_q <= 1'b0;
            oovf_q  <= 1'b0;
            oinx_q  <= 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: if (in_valid) begin
                    fr_q   <= in_fr;
                    er_q   <= in_er;
                    db_q   <= in_db;
                    sign_q <= in_sign;
                    rm_q   <= rm_e'(in_rm);
                end
                ST_FLAG: begin
                    tiny_q <= fl_tiny;
                    ovf1_q <= fl_ovf1;
                    lz_q   <= fl_lz;
                end
                ST_NORM: begin
                    fn_q <= fr_q << lz_q;
                    en_q <= er_q - ER_W'(lz_q);
                end
                ST_RND: begin
                    sig_q   <= sig_d;
                    exp_q   <= exp_d;
                    osign_q <= sign_q;
                    otiny_q <= tiny_d;
                    oovf_q  <= ovf_d;
                    oinx_q  <= inx_d;
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_OUT);
    assign out_sig   = sig_q;
    assign out_exp   = exp_q;
    assign out_sign  = osign_q;
    assign out_tiny  = otiny_q;
    assign out_ovf   = oovf_q;
    assign out_inx   = oinx_q;

`ifdef RND_STICKY_FLAGS_EN
    logic [2:0] sticky_q;

    // Accumulate flags per delivered result; a coincident clear keeps only the new result.
    always_ff @(posedge clk) begin
        if (rst) begin
            sticky_q <= '0;
        end else if (out_valid && out_ready) begin
            sticky_q <= flags_clr ? {oovf_q, otiny_q, oinx_q}
                                  : (sticky_q | {oovf_q, otiny_q, oinx_q});
        end else if (flags_clr) begin
            sticky_q <= '0;
        end
    end

    assign sticky_flags = sticky_q;
`else
    logic unused_flags_clr;
    assign unused_flags_clr = flags_clr;
    assign sticky_flags     = '0;
`endif

endmodule
